detdm: RTL and testbench

DETDM -- requirements
Module: detdm

---
 rtl/detdm_if.sv | 22 ++
 rtl/detdm.sv | 94 +++++++++
 tb/tb_detdm.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/detdm_if.sv
// Narrow-to-wide TDM link bundle: chunk input side and assembled word output side.
interface detdm_if #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 16
);
  logic [WIDTH_IN-1:0]  i_data_in;
  logic                 i_valid_in;
  logic                 i_ready_out;
  logic [WIDTH_OUT-1:0] o_data_out;
  logic                 o_valid_out;
  logic                 o_ready_in;

  modport master (
    output i_data_in, i_valid_in, o_ready_in,
    input  i_ready_out, o_data_out, o_valid_out
  );

  modport slave (
    input  i_data_in, i_valid_in, o_ready_in,
    output i_ready_out, o_data_out, o_valid_out
  );
endinterface

// File: rtl/detdm.sv
// TDM de-multiplexer: assembles RATIO narrow chunks (LSB first) into one wide word
// and queues finished words in a 2-entry output FIFO.
module detdm #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 16
) (
  input  logic clk,
  input  logic rst,
  detdm_if.slave bus
);

  localparam int RATIO   = (WIDTH_IN > 0) ? WIDTH_OUT / WIDTH_IN : 0;
  localparam int CNT_W   = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int TOP_LSB = (RATIO > 0) ? (RATIO - 1) * WIDTH_IN : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  if (WIDTH_IN < 1 || (WIDTH_OUT % WIDTH_IN) != 0 || RATIO < 2) begin : g_param_check
    $fatal(1, "detdm: WIDTH_OUT must be an integer multiple (>=2) of WIDTH_IN");
  end

  logic [CNT_W-1:0]     cnt;
  logic [WIDTH_OUT-1:0] asm_q;
  logic [WIDTH_OUT-1:0] head_q;
  logic [WIDTH_OUT-1:0] tail_q;
  logic [1:0]           fifo_count;
  logic [WIDTH_OUT-1:0] word;
  logic                 last;
  logic                 ready;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // ready depends only on registered state, never on the handshake inputs
  assign last   = (cnt == CNT_LAST);
  assign ready  = !last || (fifo_count != 2'd2);
  assign accept = bus.i_valid_in && ready;
  assign push   = accept && last;
  assign pop    = (fifo_count != 2'd0) && bus.o_ready_in;

  always_comb begin
    word = asm_q;
    word[TOP_LSB +: WIDTH_IN] = bus.i_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (accept) begin
      if (last) begin
        cnt   <= '0;
        asm_q <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        asm_q[cnt * WIDTH_IN +: WIDTH_IN] <= bus.i_data_in;
      end
    end
  end

  // head_q is always the oldest entry, so o_data_out comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      fifo_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) head_q <= word;
          else                    tail_q <= word;
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          head_q     <= tail_q;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd2) begin
            head_q <= tail_q;
            tail_q <= word;
          end else begin
            head_q <= word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i_ready_out = ready;
  assign bus.o_valid_out = (fifo_count != 2'd0);
  assign bus.o_data_out  = head_q;

endmodule

// File: tb/tb_detdm.sv
// Directed and random-stress bench for detdm with WIDTH_IN=4, WIDTH_OUT=16.
module tb_detdm;
  localparam int WI = 4;
  localparam int WO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  detdm_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus();

  detdm #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled on the falling edge, then inputs for the next rising edge are driven.
  task automatic step(input logic v, input logic [3:0] d, input logic r,
                      output logic sv, output logic [15:0] sd, output logic srdy);
    @(negedge clk);
    sv   = bus.o_valid_out;
    sd   = bus.o_data_out;
    srdy = bus.i_ready_out;
    bus.i_valid_in = v;
    bus.i_data_in  = d;
    bus.o_ready_in = r;
  endtask

  task automatic test_reset();
    bus.i_valid_in = 1'b0;
    bus.i_data_in  = 4'h0;
    bus.o_ready_in = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (bus.o_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid_out); end
      vectors++;
      if (bus.o_data_out !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", bus.o_data_out); end
      vectors++;
      if (bus.i_ready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.i_ready_out); end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.i_ready_out !== 1'b1 || bus.o_valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: ready=%b valid=%b expected ready=1 valid=0", bus.i_ready_out, bus.o_valid_out);
    end
  endtask

  task automatic test_single();
    logic [3:0] ch [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
    logic sv, srdy;
    logic [15:0] sd;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(cyc < 4, (cyc < 4) ? ch[cyc] : 4'h0, 1'b1, sv, sd, srdy);
      vectors++;
      if (sv !== (cyc == 4)) begin miscompares++; $display("FAIL single_valid cyc%0d: got %b expected %b", cyc, sv, cyc == 4); end
      if (cyc == 4) begin
        vectors++;
        if (sd !== 16'hABCD) begin miscompares++; $display("FAIL single_data: got %h expected abcd", sd); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ch [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
    logic sv, srdy;
    logic [15:0] sd;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(cyc < 8, (cyc < 8) ? ch[cyc] : 4'h0, 1'b1, sv, sd, srdy);
      if (cyc < 8) begin
        vectors++;
        if (srdy !== 1'b1) begin miscompares++; $display("FAIL b2b_ready cyc%0d: got %b expected 1", cyc, srdy); end
      end
      vectors++;
      if (sv !== (cyc == 4 || cyc == 8)) begin miscompares++; $display("FAIL b2b_valid cyc%0d: got %b expected %b", cyc, sv, cyc == 4 || cyc == 8); end
      if (cyc == 4) begin
        vectors++;
        if (sd !== 16'h1234) begin miscompares++; $display("FAIL b2b_word0: got %h expected 1234", sd); end
      end
      if (cyc == 8) begin
        vectors++;
        if (sd !== 16'h5678) begin miscompares++; $display("FAIL b2b_word1: got %h expected 5678", sd); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_w [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic sv, srdy, v, r;
    logic [15:0] sd;
    int idx = 0;
    int npop = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      r = (cyc >= 15);
      v = (idx < 12);
      step(v, 4'((idx / 4) + 1), r, sv, sd, srdy);
      if (cyc <= 10 || cyc == 16) begin
        vectors++;
        if (srdy !== 1'b1) begin miscompares++; $display("FAIL bp_ready_hi cyc%0d: got %b expected 1", cyc, srdy); end
      end else if (cyc <= 15) begin
        vectors++;
        if (srdy !== 1'b0) begin miscompares++; $display("FAIL bp_ready_lo cyc%0d: got %b expected 0", cyc, srdy); end
      end
      if (cyc >= 11 && cyc <= 14) begin
        vectors++;
        if (sv !== 1'b1 || sd !== 16'h1111) begin
          miscompares++;
          $display("FAIL bp_hold cyc%0d: valid=%b data=%h expected valid=1 data=1111", cyc, sv, sd);
        end
      end
      if (sv && r) begin
        vectors++;
        if (npop >= 3) begin
          miscompares++;
          $display("FAIL bp_extra_word: got %h expected no more words", sd);
        end else if (sd !== exp_w[npop]) begin
          miscompares++;
          $display("FAIL bp_order word%0d: got %h expected %h", npop, sd, exp_w[npop]);
        end
        npop++;
      end
      if (v && srdy) idx++;
    end
    vectors++;
    if (npop != 3 || idx != 12) begin
      miscompares++;
      $display("FAIL bp_counts: words=%0d chunks=%0d expected words=3 chunks=12", npop, idx);
    end
  endtask

  task automatic test_gap();
    logic        vv [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  dd [10] = '{4'hD, 4'hC, 4'hF, 4'h7, 4'hF, 4'hB, 4'hA, 4'h3, 4'h0, 4'h0};
    logic sv, srdy;
    logic [15:0] sd;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step(vv[cyc], dd[cyc], 1'b1, sv, sd, srdy);
      vectors++;
      if (sv !== (cyc == 7)) begin miscompares++; $display("FAIL gap_valid cyc%0d: got %b expected %b", cyc, sv, cyc == 7); end
      if (cyc == 7) begin
        vectors++;
        if (sd !== 16'hABCD) begin miscompares++; $display("FAIL gap_data: got %h expected abcd", sd); end
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [3:0] ch [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
    logic sv, srdy;
    logic [15:0] sd;
    step(1'b1, 4'h5, 1'b1, sv, sd, srdy);
    step(1'b1, 4'h6, 1'b1, sv, sd, srdy);
    step(1'b0, 4'h0, 1'b1, sv, sd, srdy);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_valid_out !== 1'b0 || bus.i_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_during: valid=%b ready=%b expected valid=0 ready=1", bus.o_valid_out, bus.i_ready_out);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.o_valid_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_edge_valid: got %b expected 0", bus.o_valid_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(cyc < 4, (cyc < 4) ? ch[cyc] : 4'h0, 1'b1, sv, sd, srdy);
      vectors++;
      if (sv !== (cyc == 4)) begin miscompares++; $display("FAIL rstmid_valid cyc%0d: got %b expected %b", cyc, sv, cyc == 4); end
      if (cyc == 4) begin
        vectors++;
        if (sd !== 16'hABCD) begin miscompares++; $display("FAIL rstmid_data: got %h expected abcd", sd); end
      end
    end
    // Word queued plus a partial word, then reset: nothing from before reset may surface.
    for (int k = 0; k < 6; k++) step(1'b1, 4'h9, 1'b0, sv, sd, srdy);
    step(1'b0, 4'h0, 1'b0, sv, sd, srdy);
    vectors++;
    if (sv !== 1'b1 || sd !== 16'h9999) begin
      miscompares++;
      $display("FAIL rstfifo_pre: valid=%b data=%h expected valid=1 data=9999", sv, sd);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_valid_out !== 1'b0 || bus.o_data_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL rstfifo_clear: valid=%b data=%h expected valid=0 data=0000", bus.o_valid_out, bus.o_data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step(1'b0, 4'h0, 1'b1, sv, sd, srdy);
      vectors++;
      if (sv !== 1'b0) begin miscompares++; $display("FAIL rstfifo_leak cyc%0d: got valid=%b data=%h expected valid=0", cyc, sv, sd); end
    end
  endtask

  task automatic test_stress();
    logic [15:0] q [$];
    int m_cnt = 0;
    logic [15:0] m_asm = 16'h0;
    logic v, r, sv, srdy, exp_rdy, exp_v, pv, pr;
    logic [3:0] d;
    logic [15:0] sd, pd;
    int nwords = 0;
    pv = 1'b0; pr = 1'b1; pd = 16'h0;
    @(negedge clk);
    bus.i_valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 2) != 0);
      exp_rdy = (m_cnt != 3) || (q.size() < 2);
      exp_v   = (q.size() != 0);
      step(v, d, r, sv, sd, srdy);
      vectors++;
      if (srdy !== exp_rdy) begin miscompares++; $display("FAIL stress_ready c%0d: got %b expected %b", c, srdy, exp_rdy); end
      vectors++;
      if (sv !== exp_v) begin miscompares++; $display("FAIL stress_valid c%0d: got %b expected %b", c, sv, exp_v); end
      if (exp_v) begin
        vectors++;
        if (sd !== q[0]) begin miscompares++; $display("FAIL stress_data c%0d: got %h expected %h", c, sd, q[0]); end
      end
      if (pv && !pr) begin
        vectors++;
        if (sv !== 1'b1 || sd !== pd) begin
          miscompares++;
          $display("FAIL stress_stable c%0d: valid=%b data=%h expected valid=1 data=%h", c, sv, sd, pd);
        end
      end
      if (exp_v && r) begin q.pop_front(); nwords++; end
      if (v && exp_rdy) begin
        if (m_cnt == 3) begin
          q.push_back({d, m_asm[11:0]});
          m_cnt = 0;
          m_asm = 16'h0;
        end else begin
          m_asm[m_cnt * 4 +: 4] = d;
          m_cnt++;
        end
      end
      pv = sv; pr = r; pd = sd;
    end
    vectors++;
    if (nwords < 100) begin miscompares++; $display("FAIL stress_throughput: got %0d words expected at least 100", nwords); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_reset_midword();
    test_stress();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
